// File: rtl/cpu_pkg.sv
// cpu_pkg: shared instruction-store geometry and program-loader state encoding.
package cpu_pkg;
    localparam int IMEM_DEPTH  = 16;
    localparam int IMEM_ADDR_W = 4;
    localparam int INSTR_W     = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_DONE,
        S_ERR
    } ld_state_t;
endpackage

// File: rtl/checksum8.sv
// checksum8: 8-bit modular byte accumulator.
// Ports: clk, reset (sync, active-high), clr (restart at zero), en (add data), data, sum.
module checksum8
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               en,
    input  logic [INSTR_W-1:0] data,
    output logic [INSTR_W-1:0] sum
);
    always_ff @(posedge clk) begin
        if (reset || clr)
            sum <= '0;
        else if (en)
            sum <= sum + data;
    end
endmodule

// File: rtl/program_loader.sv
// program_loader: streams DEPTH program bytes plus a checksum into the instruction store.
// Ports: clk, reset (sync, active-high), start, in_valid/in_data/in_ready (byte stream),
//        mem_we/mem_addr/mem_wdata (store write port), cpu_hold, busy, done, error.
module program_loader
    import cpu_pkg::*;
#(
    parameter int DEPTH  = IMEM_DEPTH,
    parameter int ADDR_W = IMEM_ADDR_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               in_valid,
    input  logic [INSTR_W-1:0] in_data,
    output logic               in_ready,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [INSTR_W-1:0] mem_wdata,
    output logic               cpu_hold,
    output logic               busy,
    output logic               done,
    output logic               error
);
    ld_state_t          state, state_nx;
    logic [ADDR_W-1:0]  idx;
    logic [INSTR_W-1:0] sum;
    logic [INSTR_W-1:0] total;
    logic               xfer, load_acc, restart;

    assign in_ready = (state == S_LOAD) || (state == S_CHECK);
    assign busy     = in_ready;
    assign done     = state == S_DONE;
    assign error    = state == S_ERR;
    assign cpu_hold = state != S_DONE;
    assign xfer     = in_valid && in_ready;
    assign load_acc = xfer && (state == S_LOAD);
    assign restart  = start && !in_ready;
    assign total    = sum + in_data;

    checksum8 u_sum (
        .clk  (clk),
        .reset(reset),
        .clr  (restart),
        .en   (load_acc),
        .data (in_data),
        .sum  (sum)
    );

    always_ff @(posedge clk) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (restart)
            state_nx = S_LOAD;
        else if (load_acc && idx == ADDR_W'(DEPTH - 1))
            state_nx = S_CHECK;
        else if (xfer && state == S_CHECK)
            state_nx = (total == '0) ? S_DONE : S_ERR;
    end

    // Write port is registered: an accepted byte appears on mem_* for exactly the next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx       <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we <= load_acc;
            if (restart)
                idx <= '0;
            if (load_acc) begin
                mem_addr  <= idx;
                mem_wdata <= in_data;
                idx       <= idx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed self-checking bench for program_loader.
module tb_program_loader;
    import cpu_pkg::*;

    logic       clk = 1'b0;
    logic       reset, start, in_valid;
    logic [7:0] in_data;
    logic       in_ready, mem_we, cpu_hold, busy, done, error;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata;

    int total = 0;
    int bad   = 0;
    int xfers = 0;
    int wr_cnt = 0;
    int wb, xb;

    logic [7:0] mem   [16];
    logic [3:0] log_a [512];
    logic [7:0] log_d [512];
    logic [7:0] prog  [16] = '{8'hA6, 8'hAF, 8'hB4, 8'hBD, 8'h10, 8'h31, 8'h41, 8'h61,
                               8'h88, 8'hF8, 8'hCB, 8'h9B, 8'hA7, 8'h7B, 8'h00, 8'h00};

    always #5 clk = ~clk;

    program_loader dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .cpu_hold (cpu_hold),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    always @(posedge clk) begin
        if (in_valid && in_ready)
            xfers <= xfers + 1;
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
            log_a[wr_cnt] <= mem_addr;
            log_d[wr_cnt] <= mem_wdata;
            wr_cnt        <= wr_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready)
            check("ready_timeout", 0, 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_range(input int from, input int to, input int gap);
        for (int i = from; i < to; i++) begin
            send(prog[i]);
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic check_writes(input string tag, input int base);
        int e = 0;
        for (int i = 0; i < 16; i++)
            if (log_a[base+i] !== 4'(i) || log_d[base+i] !== prog[i])
                e++;
        check({tag, "_wcnt"}, wr_cnt - base, 16);
        check({tag, "_wseq"}, e, 0);
    endtask

    task automatic check_mem(input string tag);
        int e = 0;
        for (int i = 0; i < 16; i++)
            if (mem[i] !== prog[i])
                e++;
        check({tag, "_mem"}, e, 0);
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst_hold", cpu_hold, 1);
        check("rst_we", mem_we, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", error, 0);
        check("rst_rdy", in_ready, 0);

        // good load, back-to-back
        wb = wr_cnt;
        xb = xfers;
        pulse_start();
        send_range(0, 16, 0);
        send(8'h4F);
        check("good_cs_nowr", mem_we, 0);
        check("good_done", done, 1);
        check("good_hold", cpu_hold, 0);
        check("good_err", error, 0);
        check("good_xfers", xfers - xb, 17);
        check_writes("good", wb);

        // bad checksum
        wb = wr_cnt;
        pulse_start();
        send_range(0, 16, 0);
        send(8'h50);
        check("bad_err", error, 1);
        check("bad_done", done, 0);
        check("bad_hold", cpu_hold, 1);
        check_writes("bad", wb);
        check_mem("bad");

        // gaps of 3 idle cycles after every byte
        wb = wr_cnt;
        pulse_start();
        send_range(0, 16, 3);
        send(8'h4F);
        check("gap_done", done, 1);
        check_writes("gap", wb);
        check_mem("gap");

        // reset after byte 7 is accepted
        wb = wr_cnt;
        pulse_start();
        send_range(0, 8, 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_state", dut.state, S_IDLE);
        check("mid_hold", cpu_hold, 1);
        check("mid_we", mem_we, 0);
        xb = xfers;
        in_valid = 1'b1;
        in_data  = 8'hFF;
        repeat (4) @(negedge clk);
        in_valid = 1'b0;
        check("mid_noxfer", xfers - xb, 0);
        check("mid_wcnt", wr_cnt - wb, 8);
        wb = wr_cnt;
        pulse_start();
        send_range(0, 16, 0);
        send(8'h4F);
        check("fresh_done", done, 1);
        check_writes("fresh", wb);

        // start ignored in LOAD, honoured in DONE
        wb = wr_cnt;
        pulse_start();
        send_range(0, 5, 0);
        pulse_start();
        check("ign_idx", dut.idx, 5);
        check("ign_sum", dut.sum, 8'hD6);
        check("ign_busy", busy, 1);
        send_range(5, 16, 0);
        send(8'h4F);
        check("ign_done", done, 1);
        check_writes("ign", wb);
        pulse_start();
        check("rest_busy", busy, 1);
        check("rest_hold", cpu_hold, 1);
        check("rest_done", done, 0);

        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
